multicycle_ctrl: RTL

- Main control FSM for the multi-cycle RV32I core.
- Sequences instruction fetch, decode, execute, memory access and writeback over one shared memory port.
- Drives the immediate generator, ALU, PC, IR and register-file enables and muxes.
- Sits between the instruction register and the datapath muxes; owns the memory request/acknowledge handshake.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states,
// instruction classes and datapath mux selects.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } iclass_e;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // Timeout counter must hold MEM_TIMEOUT itself; never narrower than 1 bit.
    function automatic int unsigned tcnt_w(int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the control FSM and the memory.
interface multicycle_ctrl_if;
    logic memReq;
    logic memWe;
    logic memAddrSel;
    logic memAck;

    modport master (output memReq, memWe, memAddrSel, input memAck);
    modport slave  (input memReq, memWe, memAddrSel, output memAck);
endinterface

// File: rtl/ctrl_decode.sv
// Opcode classifier: instr[6:0] -> instruction class plus illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_e    cls,
    output logic       illegal
);

    always_comb begin
        cls     = C_R;
        illegal = 1'b0;
        case (opcode)
            OP_R:      cls = C_R;
            OP_IALU:   cls = C_IALU;
            OP_LOAD:   cls = C_LOAD;
            OP_STORE:  cls = C_STORE;
            OP_BRANCH: cls = C_BRANCH;
            OP_JAL:    cls = C_JAL;
            OP_JALR:   cls = C_JALR;
            OP_LUI:    cls = C_LUI;
            OP_AUIPC:  cls = C_AUIPC;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional PERF_CNT_EN adds cycleCnt/instretCnt performance counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  mem,
    input  logic [31:0]        instr,
    input  logic               branchTaken,
    output logic               irWrite,
    output logic               pcWrite,
    output logic [1:0]         pcSel,
    output logic               aluSrcA,
    output logic               aluSrcB,
    output logic               regWrite,
    output logic [1:0]         wbSel,
    output logic               retire,
    output logic               trap
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]        cycleCnt,
    output logic [31:0]        instretCnt
`endif
);

    localparam int unsigned TW = tcnt_w(MEM_TIMEOUT);

    state_e          state, state_nxt;
    iclass_e         cls_d, cls_q;
    logic            illegal;
    logic            run;
    logic [TW-1:0]   tcnt, tcnt_nxt, tcnt_inc;
    logic            wait_st, timeout;
    logic            mem_req, mem_we, mem_addr_sel;

    wire unused_instr = ^instr[31:7];

    ctrl_decode u_decode (
        .opcode  (instr[6:0]),
        .cls     (cls_d),
        .illegal (illegal)
    );

    // run holds every output low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cls_q <= C_R;
            tcnt  <= '0;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            if (state == S_DECODE)
                cls_q <= cls_d;
        end
    end

    assign wait_st  = run && (state == S_FETCH || state == S_MEM) && !mem.memAck;
    assign tcnt_inc = tcnt + TW'(1);
    assign timeout  = wait_st && (MEM_TIMEOUT != 0) && (tcnt_inc == TW'(MEM_TIMEOUT));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (run) begin
                    if (mem.memAck)  state_nxt = S_DECODE;
                    else if (timeout) state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH:        state_nxt = S_FETCH;
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    default:         state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.memAck)   state_nxt = (cls_q == C_STORE) ? S_FETCH : S_WB;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_WB:    state_nxt = S_FETCH;
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_TRAP;
        endcase
    end

    // Counter restarts on every state change, so FETCH and MEM each get a full budget.
    always_comb begin
        tcnt_nxt = tcnt;
        if (state_nxt != state) tcnt_nxt = '0;
        else if (wait_st)       tcnt_nxt = tcnt_inc;
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSel        = PC_PLUS4;
        aluSrcA      = 1'b0;
        aluSrcB      = 1'b0;
        regWrite     = 1'b0;
        wbSel        = WB_ALU;
        retire       = 1'b0;
        trap         = 1'b0;
        case (state)
            S_FETCH: begin
                if (run) begin
                    mem_req = 1'b1;
                    irWrite = mem.memAck;
                end
            end
            S_DECODE: trap = illegal;
            S_EXEC: begin
                case (cls_q)
                    C_IALU, C_LOAD, C_STORE, C_JALR: aluSrcB = 1'b1;
                    C_AUIPC: begin
                        aluSrcA = 1'b1;
                        aluSrcB = 1'b1;
                    end
                    C_BRANCH: begin
                        pcWrite = 1'b1;
                        pcSel   = branchTaken ? PC_IMM : PC_PLUS4;
                        retire  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == C_STORE);
                if (mem.memAck && cls_q == C_STORE) begin
                    pcWrite = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                retire   = 1'b1;
                case (cls_q)
                    C_LOAD:  wbSel = WB_MEM;
                    C_JAL:   begin wbSel = WB_PC4; pcSel = PC_IMM;  end
                    C_JALR:  begin wbSel = WB_PC4; pcSel = PC_JALR; end
                    C_LUI:   wbSel = WB_IMM;
                    default: wbSel = WB_ALU;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b1;
        endcase
    end

    assign mem.memReq     = mem_req;
    assign mem.memWe      = mem_we;
    assign mem.memAddrSel = mem_addr_sel;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt   <= '0;
            instretCnt <= '0;
        end else if (state != S_TRAP) begin
            cycleCnt <= cycleCnt + 32'd1;
            if (retire)
                instretCnt <= instretCnt + 32'd1;
        end
    end
`endif

endmodule
